// File: rtl/scene_mixer_if.sv
// Purpose: bundles the compositor inputs (layers, screen colours, game events) and its pixel/mode outputs.
// Latency: none, wiring only.
// Backpressure: none; the pixel stream runs at full rate with no ready path.
interface scene_mixer_if #(
    parameter int NUM_LAYERS = 8,
    parameter int RGB_W      = 12
);
    localparam int IDX_W = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;

    logic [NUM_LAYERS-1:0]       layer_en;
    logic [NUM_LAYERS-1:0]       layer_key_en;
    logic [NUM_LAYERS*RGB_W-1:0] layer_rgb;
    logic [RGB_W-1:0]            background_rgb;
    logic [RGB_W-1:0]            start_rgb;
    logic [RGB_W-1:0]            end_rgb;
    logic                        frame_start;
    logic                        start_key;
    logic                        game_over;

    logic [RGB_W-1:0]            pix_rgb;
    logic                        hit_valid;
    logic [IDX_W-1:0]            hit_layer;
    logic [1:0]                  mode;
    logic                        game_rst;

    // Upstream side: element judges, video timing and the VGA driver.
    modport master (
        output layer_en, layer_key_en, layer_rgb, background_rgb, start_rgb, end_rgb,
               frame_start, start_key, game_over,
        input  pix_rgb, hit_valid, hit_layer, mode, game_rst
    );

    // The mixer itself.
    modport slave (
        input  layer_en, layer_key_en, layer_rgb, background_rgb, start_rgb, end_rgb,
               frame_start, start_key, game_over,
        output pix_rgb, hit_valid, hit_layer, mode, game_rst
    );
endinterface

// File: rtl/scene_mixer.sv
// Purpose: priority-composites NUM_LAYERS keyed layers over a background and runs the START/PLAY/OVER screen FSM.
// Latency: 2 clk from layer inputs to pix_rgb/hit_*; mode changes only on frame_start cycles.
// Backpressure: none; accepts one pixel per clock, requests are held in a one-entry pending flag.
module scene_mixer #(
    parameter int               NUM_LAYERS      = 8,
    parameter int               RGB_W           = 12,
    parameter logic [RGB_W-1:0] KEY_COLOR       = '0,
    parameter int               END_HOLD_FRAMES = 120
) (
    input  logic          clk,
    input  logic          rst,
    scene_mixer_if.slave  bus
);
    localparam int IDX_W  = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
    localparam int HOLD_W = (END_HOLD_FRAMES > 0) ? $clog2(END_HOLD_FRAMES + 1) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(END_HOLD_FRAMES);

    typedef enum logic [1:0] {
        MODE_START = 2'd0,
        MODE_PLAY  = 2'd1,
        MODE_OVER  = 2'd2
    } mode_t;

    mode_t              mode, mode_nxt;
    logic               pend_vld, pend_nxt;
    logic [HOLD_W-1:0]  hold_cnt, hold_nxt;
    logic               go_armed;
    logic               in_play_q;
    logic               game_rst_q;
    logic               req;
    logic               pend_eff;

    // Stage-1 winner search and registers.
    logic               win_found;
    logic [IDX_W-1:0]   win_idx;
    logic [RGB_W-1:0]   win_rgb;
    logic               s1_found;
    logic [IDX_W-1:0]   s1_idx;
    logic [RGB_W-1:0]   s1_rgb;
    logic [RGB_W-1:0]   s1_bg;
    logic [RGB_W-1:0]   s1_start;
    logic [RGB_W-1:0]   s1_end;
    mode_t              s1_mode;

    // Stage-2 output registers.
    logic [RGB_W-1:0]   pix_q;
    logic               hit_vld_q;
    logic [IDX_W-1:0]   hit_layer_q;

    // Screen FSM next state: latch the request for this mode, apply it only on frame_start.
    always_comb begin
        mode_nxt = mode;
        pend_nxt = pend_vld;
        hold_nxt = hold_cnt;
        req      = 1'b0;
        unique case (mode)
            MODE_START: req = bus.start_key;
            MODE_PLAY:  req = bus.game_over && go_armed;
            MODE_OVER:  req = bus.start_key && (hold_cnt == '0);
            default:    req = 1'b0;
        endcase
        pend_eff = pend_vld || req;
        if (bus.frame_start) begin
            pend_nxt = 1'b0;
            unique case (mode)
                MODE_START: begin
                    if (pend_eff) mode_nxt = MODE_PLAY;
                end
                MODE_PLAY: begin
                    if (pend_eff) begin
                        mode_nxt = MODE_OVER;
                        hold_nxt = HOLD_LOAD;
                    end
                end
                MODE_OVER: begin
                    if (pend_eff)
                        mode_nxt = MODE_PLAY;
                    else if (hold_cnt == '0)
                        mode_nxt = MODE_START;
                    else
                        hold_nxt = hold_cnt - HOLD_W'(1);
                end
                default: mode_nxt = MODE_START;
            endcase
        end else begin
            pend_nxt = pend_eff;
        end
    end

    // Screen FSM state, pending request and OVER hold counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode     <= MODE_START;
            pend_vld <= 1'b0;
            hold_cnt <= '0;
        end else begin
            mode     <= mode_nxt;
            pend_vld <= pend_nxt;
            hold_cnt <= hold_nxt;
        end
    end

    // game_over is only trusted after it has been seen low in this PLAY session; game_rst fires the cycle after PLAY entry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            go_armed   <= 1'b0;
            in_play_q  <= 1'b0;
            game_rst_q <= 1'b0;
        end else begin
            go_armed   <= (mode == MODE_PLAY) && (go_armed || !bus.game_over);
            in_play_q  <= (mode == MODE_PLAY);
            game_rst_q <= (mode == MODE_PLAY) && !in_play_q;
        end
    end

    // Lowest-index qualifying layer wins; keyed layers showing KEY_COLOR are see-through.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        win_rgb   = '0;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (bus.layer_en[i] &&
                !(bus.layer_key_en[i] && (bus.layer_rgb[i*RGB_W +: RGB_W] == KEY_COLOR))) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(i);
                win_rgb   = bus.layer_rgb[i*RGB_W +: RGB_W];
            end
        end
    end

    // Stage 1: capture the winner, the screen colours and the mode seen by this pixel.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_found <= 1'b0;
            s1_idx   <= '0;
            s1_rgb   <= '0;
            s1_bg    <= '0;
            s1_start <= '0;
            s1_end   <= '0;
            s1_mode  <= MODE_START;
        end else begin
            s1_found <= win_found;
            s1_idx   <= win_idx;
            s1_rgb   <= win_rgb;
            s1_bg    <= bus.background_rgb;
            s1_start <= bus.start_rgb;
            s1_end   <= bus.end_rgb;
            s1_mode  <= mode;
        end
    end

    // Stage 2: pick the final pixel by screen mode; hits are only reported in PLAY.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pix_q       <= '0;
            hit_vld_q   <= 1'b0;
            hit_layer_q <= '0;
        end else begin
            hit_vld_q   <= 1'b0;
            hit_layer_q <= '0;
            unique case (s1_mode)
                MODE_START: pix_q <= s1_start;
                MODE_PLAY: begin
                    if (s1_found) begin
                        pix_q       <= s1_rgb;
                        hit_vld_q   <= 1'b1;
                        hit_layer_q <= s1_idx;
                    end else begin
                        pix_q <= s1_bg;
                    end
                end
                default: pix_q <= s1_end;
            endcase
        end
    end

    assign bus.pix_rgb   = pix_q;
    assign bus.hit_valid = hit_vld_q;
    assign bus.hit_layer = hit_layer_q;
    assign bus.mode      = mode;
    assign bus.game_rst  = game_rst_q;
endmodule

// File: doc/scene_mixer.md
Name: scene_mixer

Overview:
- Parametrised successor to the fixed-priority pixel selector in the game top level.
- Merges NUM_LAYERS sprite/bullet/HUD layers over a background.
- Supports per-layer transparency keying and a frame-synchronous START/PLAY/OVER screen state machine.
- Sits between the element judges and the VGA driver. Emits a registered pixel with fixed latency and a one-cycle game reset pulse on entering PLAY.

Parameters:
- NUM_LAYERS, 8: number of overlay layers; index 0 is the highest priority.
- RGB_W, 12: pixel colour width.
- KEY_COLOR, 12'h000: colour treated as transparent when keying is enabled for a layer.
- END_HOLD_FRAMES, 120: frames the OVER screen is held before it may be left; 0 is legal.

Ports:
- clk  in  1  pixel clock (25.175 MHz domain).
- rst  in  1  asynchronous, active-low reset (0 = reset).
- layer_en  in  NUM_LAYERS  per-layer "pixel belongs to layer" flag for the current (x,y).
- layer_key_en  in  NUM_LAYERS  per-layer transparency keying enable.
- layer_rgb  in  NUM_LAYERS*RGB_W  packed layer colours; layer i occupies bits [i*RGB_W +: RGB_W].
- background_rgb  in  RGB_W  PLAY-mode background colour.
- start_rgb  in  RGB_W  START-screen colour.
- end_rgb  in  RGB_W  OVER-screen colour.
- frame_start  in  1  one-cycle pulse per frame, issued during vertical blanking.
- start_key  in  1  one-cycle "enter" pulse.
- game_over  in  1  level; high while player health is 0.
- pix_rgb  out  RGB_W  composited pixel, registered.
- hit_valid  out  1  registered; high when an overlay layer won this pixel.
- hit_layer  out  $clog2(NUM_LAYERS)  registered index of the winning layer; 0 when hit_valid = 0.
- mode  out  2  current screen: 0 = START, 1 = PLAY, 2 = OVER.
- game_rst  out  1  one-cycle pulse on entry to PLAY.

Behaviour:
Reset (rst = 0, asynchronous):
- mode = START; pix_rgb = 0; hit_valid = 0; hit_layer = 0; game_rst = 0.
- Pending request cleared; hold counter cleared; pipeline registers cleared.

Layer qualification:
- Layer i qualifies when layer_en[i] = 1 AND NOT (layer_key_en[i] = 1 AND layer_rgb[i] == KEY_COLOR).

Pipeline (latency exactly 2 clk, full throughput):
- Stage 1 registers:
  - the lowest qualifying index and a "found" flag;
  - that layer's colour;
  - background_rgb, start_rgb and end_rgb;
  - the mode value current in that cycle.
- Stage 2 registers pix_rgb using the stage-1 mode:
  - START → start_rgb.
  - OVER → end_rgb.
  - PLAY → winning layer colour if found, else background_rgb.
- hit_valid / hit_layer are registered in stage 2 with pix_rgb. They are 0 outside PLAY.

Mode FSM (mode changes only on a frame_start cycle, so no mid-frame tearing):
- Requests are latched into a one-entry pending register:
  - START: start_key sets pending = PLAY.
  - PLAY: game_over = 1 sets pending = OVER. game_over overrides a same-cycle start_key; start_key is ignored in PLAY.
  - OVER: start_key sets pending = PLAY, but only once the hold has expired.
- On frame_start, a pending request (including one raised in the same cycle) is applied and the pending register is cleared.
- PLAY entry:
  - game_rst pulses high in the cycle after mode becomes PLAY.
  - Any stale game_over is ignored until it is seen low once in PLAY. This prevents immediate re-death from the previous game.
- OVER entry: the hold counter loads END_HOLD_FRAMES. Each frame_start in OVER decrements it, saturating at 0. The hold expires when the counter is 0.
- OVER auto-return: on a frame_start where the counter is already 0 and no PLAY request is pending, mode returns to START.
- END_HOLD_FRAMES = 0: the hold expires at once. Either start_key → PLAY, or OVER → START at the next frame_start.
- Reset mid-frame or mid-hold: immediate return to START; game_rst is not pulsed.

Widths:
- Hold counter is $clog2(END_HOLD_FRAMES+1) bits, minimum 1.
- No arithmetic overflow paths exist. The decrement saturates.

Test Plan:
- Reset then PLAY. Hold rst = 0, release, pulse start_key then frame_start. Expect mode 0 → 1 one cycle after frame_start, game_rst high for exactly 1 cycle, pix_rgb = background_rgb two cycles later with no layers enabled.
- Priority. PLAY, layer_en = 8'b0010_0100, layer_rgb[2] = 12'hF00, layer_rgb[5] = 12'h0F0. Expect pix_rgb = 12'hF00, hit_layer = 2, hit_valid = 1 at latency 2.
- Transparency. Same as above with layer_rgb[2] = 12'h000 and layer_key_en[2] = 1. Expect pix_rgb = 12'h0F0 and hit_layer = 5. With layer_key_en[2] = 0, expect 12'h000 and hit_layer = 2.
- Frame sync and override. Assert game_over together with start_key mid-frame in PLAY. Mode stays 1 until the next frame_start, then becomes 2. pix_rgb = end_rgb two cycles later.
- Hold. END_HOLD_FRAMES = 3. start_key during OVER frames 1–3 is ignored. After the 3rd frame_start, start_key followed by frame_start gives mode = 1 and a game_rst pulse. With no key, the 4th frame_start gives mode = 0.
- Async reset mid-OVER. Drop rst between clock edges. Outputs clear immediately without waiting for a clock edge, mode = 0, and no game_rst pulse occurs.
